// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-frame writer: pixel/word geometry,
// FIFO entry layout, write FSM states and the pixel binarisation helper.
package edge_pkg;

  localparam int PIX_W        = 4;
  localparam int PIX_PER_WORD = 4;
  localparam int WORD_W       = 16;
  localparam int SRAM_ADDR_W  = 18;

  // The entry address field is fixed at SRAM_ADDR_W; the top casts to its ADDR_W.
  typedef struct packed {
    logic                   last;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [WORD_W-1:0]      data;
  } wr_entry_t;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_REQ  = 1'b1
  } wr_state_t;

  function automatic logic [PIX_W-1:0] map_pixel(
    input logic [PIX_W-1:0] pix,
    input logic             bin_en,
    input logic [PIX_W-1:0] level
  );
    if (bin_en) begin
      return (pix >= level) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
    end
    return pix;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, registered pointers with combinational head read.
// Push on full is accepted only together with a pop; pop on empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign rd_en   = pop & ~empty;
  assign wr_en   = push & (~full | rd_en);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  // On full+pop the write lands in the slot being read; the reader has
  // already captured the old head at this edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/edge_frame_writer.sv
// Packs 4-bit edge pixels into 16-bit words and writes them to SRAM via req/ack.
// 4th pixel -> sram_we in 2 cycles; no input backpressure, words dropped when FIFO full.
module edge_frame_writer
  import edge_pkg::*;
#(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int ADDR_W     = 18,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic              in_valid,
  input  logic              thresh_en,
  input  logic [PIX_W-1:0]  threshold,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [WORD_W-1:0] sram_wdata,
  output logic              sram_we,
  input  logic              sram_ack,
  output logic              frame_done,
  output logic              overflow,
  output logic              busy
);

  localparam int WORDS   = IMG_W * IMG_H / PIX_PER_WORD;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int SHIFT_W = (PIX_PER_WORD - 1) * PIX_W;
  localparam logic [ADDR_W-1:0] WADDR_MAX = ADDR_W'(WORDS - 1);

  logic [PIX_W-1:0]   pix;
  logic [1:0]         pk_cnt;
  logic [SHIFT_W-1:0] pk_shift;
  logic [ADDR_W-1:0]  waddr;
  logic               word_done;
  wr_entry_t          push_entry;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_cnt;
  wr_entry_t          fifo_head;

  wr_state_t          state;
  wr_state_t          state_nxt;
  logic               cur_last;

  assign pix       = map_pixel(pixel_in, thresh_en, threshold);
  assign word_done = in_valid & (pk_cnt == 2'd3);

  always_comb begin
    push_entry      = '0;
    push_entry.last = (waddr == WADDR_MAX);
    push_entry.addr = SRAM_ADDR_W'(waddr);
    push_entry.data = {pix, pk_shift};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_cnt   <= '0;
      pk_shift <= '0;
      waddr    <= '0;
    end else if (in_valid) begin
      if (pk_cnt == 2'd3) begin
        pk_cnt <= '0;
        // Advances even when the word is dropped, keeping frame alignment.
        waddr  <= (waddr == WADDR_MAX) ? '0 : waddr + 1'b1;
      end else begin
        pk_shift[int'(pk_cnt)*PIX_W +: PIX_W] <= pix;
        pk_cnt <= pk_cnt + 1'b1;
      end
    end
  end

  assign fifo_push = word_done & (~fifo_full | fifo_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (word_done & fifo_full & ~fifo_pop) begin
      overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(wr_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_dat (push_entry),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WR_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      WR_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = WR_REQ;
        end
      end
      WR_REQ: begin
        if (sram_ack) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
          end else begin
            state_nxt = WR_IDLE;
          end
        end
      end
      default: state_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_addr  <= '0;
      sram_wdata <= '0;
      cur_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == WR_REQ) & sram_ack & cur_last;
      if (fifo_pop) begin
        sram_addr  <= ADDR_W'(fifo_head.addr);
        sram_wdata <= fifo_head.data;
        cur_last   <= fifo_head.last;
      end
    end
  end

  assign sram_we = (state == WR_REQ);
  assign busy    = (fifo_cnt != '0) | sram_we;

endmodule
